// File: rtl/time_entry_encoder.sv
// time_entry_encoder: collects six BCD digits (HH MM SS) one per strobe,
// range-checks each, and commits binary hours/minutes/seconds.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   digit_valid, digit      - BCD digit strobe and value
//   clear                   - synchronous abort of a partial entry
//   ready, pos              - digit acceptance and next position (6 = commit)
//   outhrs, outmin, outsec  - committed binary time
//   load, err               - one-cycle commit / reject pulses
module time_entry_encoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       clear,
   output logic       ready,
   output logic [2:0] pos,
   output logic [4:0] outhrs,
   output logic [5:0] outmin,
   output logic [5:0] outsec,
   output logic       load,
   output logic       err
);

   localparam logic [2:0] S_HT     = 3'd0;
   localparam logic [2:0] S_HO     = 3'd1;
   localparam logic [2:0] S_MT     = 3'd2;
   localparam logic [2:0] S_MO     = 3'd3;
   localparam logic [2:0] S_ST     = 3'd4;
   localparam logic [2:0] S_SO     = 3'd5;
   localparam logic [2:0] S_COMMIT = 3'd6;

   logic [2:0] r_state;
   logic [3:0] r_ht, r_ho, r_mt, r_mo, r_st, r_so;
   logic [4:0] r_hrs;
   logic [5:0] r_min, r_sec;
   logic       r_load, r_err;

   logic       w_ok;
   logic       w_take;
   logic       w_acc;
   logic       w_rej;
   logic       w_clr;
   logic [4:0] w_hrs;
   logic [5:0] w_min, w_sec;

   // Hours ones limit depends on the tens digit already staged.
   always_comb begin
      w_ok = 1'b0;
      if (digit <= 4'd9) begin
         unique case (r_state)
            S_HT:       w_ok = (digit <= 4'd2);
            S_HO:       w_ok = (r_ht != 4'd2) || (digit <= 4'd3);
            S_MT, S_ST: w_ok = (digit <= 4'd5);
            default:    w_ok = 1'b1;
         endcase
      end
   end

   assign ready  = (r_state != S_COMMIT);
   assign pos    = r_state;
   assign w_clr  = clear & ready;
   assign w_take = digit_valid & ready & ~clear;
   assign w_acc  = w_take & w_ok;
   assign w_rej  = w_take & ~w_ok;

   // Staged tens are range-limited, so these widths cannot overflow.
   assign w_hrs = {1'b0, r_ht} * 5'd10 + {1'b0, r_ho};
   assign w_min = {2'b0, r_mt} * 6'd10 + {2'b0, r_mo};
   assign w_sec = {2'b0, r_st} * 6'd10 + {2'b0, r_so};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HT;
         r_ht    <= 4'd0;
         r_ho    <= 4'd0;
         r_mt    <= 4'd0;
         r_mo    <= 4'd0;
         r_st    <= 4'd0;
         r_so    <= 4'd0;
         r_hrs   <= 5'd0;
         r_min   <= 6'd0;
         r_sec   <= 6'd0;
         r_load  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_load <= 1'b0;
         r_err  <= w_rej;
         if (r_state == S_COMMIT) begin
            // clear is ignored here; the commit always completes
            r_hrs   <= w_hrs;
            r_min   <= w_min;
            r_sec   <= w_sec;
            r_load  <= 1'b1;
            r_state <= S_HT;
         end else if (w_clr) begin
            r_state <= S_HT;
            r_ht    <= 4'd0;
            r_ho    <= 4'd0;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
         end else if (w_acc) begin
            unique case (r_state)
               S_HT:    r_ht <= digit;
               S_HO:    r_ho <= digit;
               S_MT:    r_mt <= digit;
               S_MO:    r_mo <= digit;
               S_ST:    r_st <= digit;
               default: r_so <= digit;
            endcase
            r_state <= r_state + 3'd1;
         end
      end
   end

   assign outhrs = r_hrs;
   assign outmin = r_min;
   assign outsec = r_sec;
   assign load   = r_load;
   assign err    = r_err;

endmodule

// File: tb/tb_time_entry_encoder.sv
// Directed table-driven bench for time_entry_encoder.
// Inputs change on negedge; outputs are checked 1 time unit after posedge.
module tb_time_entry_encoder;

   logic       clk;
   logic       rst_n;
   logic       digit_valid;
   logic [3:0] digit;
   logic       clear;
   logic       ready;
   logic [2:0] pos;
   logic [4:0] outhrs;
   logic [5:0] outmin;
   logic [5:0] outsec;
   logic       load;
   logic       err;

   int n_vec = 0;
   int n_bad = 0;

   time_entry_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_valid (digit_valid),
      .digit       (digit),
      .clear       (clear),
      .ready       (ready),
      .pos         (pos),
      .outhrs      (outhrs),
      .outmin      (outmin),
      .outsec      (outsec),
      .load        (load),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       c;
      logic       rdy;
      logic [2:0] p;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       ld;
      logic       er;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic v, input logic [3:0] d,
                               input logic c, input logic rdy,
                               input logic [2:0] p, input logic [4:0] h,
                               input logic [5:0] m, input logic [5:0] s,
                               input logic ld, input logic er);
      vec_t x;
      x.v = v; x.d = d; x.c = c; x.rdy = rdy; x.p = p;
      x.h = h; x.m = m; x.s = s; x.ld = ld; x.er = er;
      tbl.push_back(x);
   endfunction

   task automatic chk(input string nm, input logic rdy,
                      input logic [2:0] p, input logic [4:0] h,
                      input logic [5:0] m, input logic [5:0] s,
                      input logic ld, input logic er);
      n_vec++;
      if (ready !== rdy || pos !== p || outhrs !== h || outmin !== m ||
          outsec !== s || load !== ld || err !== er) begin
         n_bad++;
         $display("FAIL %s: got rdy=%b pos=%0d t=%0d:%0d:%0d ld=%b er=%b want rdy=%b pos=%0d t=%0d:%0d:%0d ld=%b er=%b",
                  nm, ready, pos, outhrs, outmin, outsec, load, err,
                  rdy, p, h, m, s, ld, er);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic c);
      digit_valid = v;
      digit       = d;
      clear       = c;
   endtask

   task automatic step(input string nm, input logic v, input logic [3:0] d,
                       input logic c, input logic rdy, input logic [2:0] p,
                       input logic [4:0] h, input logic [5:0] m,
                       input logic [5:0] s, input logic ld, input logic er);
      @(negedge clk);
      drive(v, d, c);
      @(posedge clk);
      #1;
      chk(nm, rdy, p, h, m, s, ld, er);
   endtask

   initial begin
      // 12:34:56
      add(1,1,0, 1,1, 0, 0, 0, 0,0);
      add(1,2,0, 1,2, 0, 0, 0, 0,0);
      add(1,3,0, 1,3, 0, 0, 0, 0,0);
      add(1,4,0, 1,4, 0, 0, 0, 0,0);
      add(1,5,0, 1,5, 0, 0, 0, 0,0);
      add(1,6,0, 0,6, 0, 0, 0, 0,0);
      add(0,0,0, 1,0,12,34,56, 1,0);
      add(0,0,0, 1,0,12,34,56, 0,0);
      // 2 then 4 rejected, then 23:59:59
      add(1,2,0, 1,1,12,34,56, 0,0);
      add(1,4,0, 1,1,12,34,56, 0,1);
      add(1,3,0, 1,2,12,34,56, 0,0);
      add(1,5,0, 1,3,12,34,56, 0,0);
      add(1,9,0, 1,4,12,34,56, 0,0);
      add(1,5,0, 1,5,12,34,56, 0,0);
      add(1,9,0, 0,6,12,34,56, 0,0);
      add(0,0,0, 1,0,23,59,59, 1,0);
      // min tens 7 and 0xA rejected, then 10:00:00
      add(1,1,0, 1,1,23,59,59, 0,0);
      add(1,0,0, 1,2,23,59,59, 0,0);
      add(1,7,0, 1,2,23,59,59, 0,1);
      add(1,10,0,1,2,23,59,59, 0,1);
      add(1,0,0, 1,3,23,59,59, 0,0);
      add(1,0,0, 1,4,23,59,59, 0,0);
      add(1,0,0, 1,5,23,59,59, 0,0);
      add(1,0,0, 0,6,23,59,59, 0,0);
      add(0,0,0, 1,0,10, 0, 0, 1,0);
      // clear wins over a digit, then 00:00:01
      add(1,0,0, 1,1,10, 0, 0, 0,0);
      add(1,9,0, 1,2,10, 0, 0, 0,0);
      add(1,3,0, 1,3,10, 0, 0, 0,0);
      add(1,1,1, 1,0,10, 0, 0, 0,0);
      add(1,0,0, 1,1,10, 0, 0, 0,0);
      add(1,0,0, 1,2,10, 0, 0, 0,0);
      add(1,0,0, 1,3,10, 0, 0, 0,0);
      add(1,0,0, 1,4,10, 0, 0, 0,0);
      add(1,0,0, 1,5,10, 0, 0, 0,0);
      add(1,1,0, 0,6,10, 0, 0, 0,0);
      add(0,0,0, 1,0, 0, 0, 1, 1,0);
      // HT>2, clear resets tens=2 check, HO>9, ST>5, clear in COMMIT
      add(1,3,0, 1,0, 0, 0, 1, 0,1);
      add(1,2,0, 1,1, 0, 0, 1, 0,0);
      add(0,0,1, 1,0, 0, 0, 1, 0,0);
      add(1,1,0, 1,1, 0, 0, 1, 0,0);
      add(1,12,0,1,1, 0, 0, 1, 0,1);
      add(1,5,0, 1,2, 0, 0, 1, 0,0);
      add(1,5,0, 1,3, 0, 0, 1, 0,0);
      add(1,9,0, 1,4, 0, 0, 1, 0,0);
      add(1,6,0, 1,4, 0, 0, 1, 0,1);
      add(1,0,0, 1,5, 0, 0, 1, 0,0);
      add(1,0,0, 0,6, 0, 0, 1, 0,0);
      add(0,0,1, 1,0,15,59, 0, 1,0);
      add(0,0,0, 1,0,15,59, 0, 0,0);
      // digit held through COMMIT is ignored
      add(1,1,0, 1,1,15,59, 0, 0,0);
      add(1,2,0, 1,2,15,59, 0, 0,0);
      add(1,3,0, 1,3,15,59, 0, 0,0);
      add(1,4,0, 1,4,15,59, 0, 0,0);
      add(1,5,0, 1,5,15,59, 0, 0,0);
      add(1,6,0, 0,6,15,59, 0, 0,0);
      add(1,9,0, 1,0,12,34,56, 1,0);
      add(1,2,0, 1,1,12,34,56, 0,0);
      add(0,0,1, 1,0,12,34,56, 0,0);

      rst_n = 1'b0;
      drive(0, 0, 0);
      #1;
      chk("reset_async", 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("reset_held", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].c,
              tbl[i].rdy, tbl[i].p, tbl[i].h, tbl[i].m, tbl[i].s,
              tbl[i].ld, tbl[i].er);
      end

      // reset mid-entry
      for (int i = 1; i <= 5; i++)
         step($sformatf("mid%0d", i), 1, 1, 0, 1, 3'(i), 12, 34, 56, 0, 0);
      #2;
      rst_n = 1'b0;
      drive(0, 0, 0);
      #1;
      chk("rst_mid", 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("rst_mid_edge", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 2, 0);
      @(posedge clk);
      #1;
      chk("first_edge_accept", 1, 1, 0, 0, 0, 0, 0);
      step("re3", 1, 3, 0, 1, 2, 0, 0, 0, 0, 0);
      step("re5", 1, 5, 0, 1, 3, 0, 0, 0, 0, 0);
      step("re9", 1, 9, 0, 1, 4, 0, 0, 0, 0, 0);
      step("re5b", 1, 5, 0, 1, 5, 0, 0, 0, 0, 0);
      step("re9b", 1, 9, 0, 0, 6, 0, 0, 0, 0, 0);
      step("re_commit", 0, 0, 0, 1, 0, 23, 59, 59, 1, 0);

      // reset while in COMMIT
      for (int i = 1; i <= 6; i++)
         step($sformatf("cm%0d", i), 1, 4'(i), 0, (i != 6), 3'(i),
              23, 59, 59, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0);
      #1;
      chk("rst_commit", 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("rst_commit_edge", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
